intersection_phase_scheduler: RTL

- Phase sequencer for the four-way (N/E/S/W) intersection. Grants green to one approach at a time: round-robin over approaches with pending vehicle requests.
- Inserts yellow and all-red clearance, pedestrian walk phases and emergency preemption.
- Drives the per-direction light codes and the countdown shown on the display path.
- Configured green duration comes from the shared data_in bus.

---
 rtl/tl_pkg.sv | 49 ++++
 rtl/phase_timer.sv | 26 ++
 rtl/intersection_phase_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the intersection phase scheduler.
// States, light codes, direction indices, default timing, direction helpers.
package tl_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED,
    ST_GREEN,
    ST_YELLOW,
    ST_PED,
    ST_EMERG
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 1;
  localparam int DEF_PED_T     = 10;
  localparam int DEF_EMERG_T   = 8;
  localparam int DEF_MIN_GREEN = 2;

  function automatic logic [3:0] dir_onehot(
    input logic [1:0] d
  );
    dir_onehot = 4'b0001 << d;
  endfunction

  // First requesting approach at or after ptr (mod 4);
  // ptr itself when nothing is requesting.
  function automatic logic [1:0] pick_dir(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [1:0] idx;
    pick_dir = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick_dir = idx;
    end
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each scheduler phase.
// Ports: clk, reset, load, load_val -> count, done (count == 1).
module phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= CNT_W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-way phase sequencer: round-robin green, yellow/all-red, walk, emergency.
// Ports: clk, reset, data_in, veh_req, ped_button, em_button, em_dir ->
//   light_n/e/s/w, grant, ped_walk, em_active, t_count. Macro: EM_PREEMPT_EN.
module intersection_phase_scheduler
  import tl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int PED_T     = DEF_PED_T,
  parameter int EMERG_T   = DEF_EMERG_T,
  parameter int MIN_GREEN = DEF_MIN_GREEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] data_in,
  input  logic [3:0]       veh_req,
  input  logic             ped_button,
  input  logic             em_button,
  input  logic [1:0]       em_dir,
  output logic [1:0]       light_n,
  output logic [1:0]       light_e,
  output logic [1:0]       light_s,
  output logic [1:0]       light_w,
  output logic [3:0]       grant,
  output logic             ped_walk,
  output logic             em_active,
  output logic [CNT_W-1:0] t_count
);

`ifdef EM_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       rr_q, rr_d;
  logic             em_flag_q, em_flag_d;
  logic             em_pend_q, ped_pend_q;
  logic [1:0]       em_dir_q;
  logic [1:0]       ped_sync_q;
  logic [CNT_W-1:0] gcnt_q;

  logic             load, done;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] green_dur;
  logic             em_clr, ped_clr;
  logic             em_same;
  logic             preempt;
  logic [7:0]       lights;

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_T)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .count   (t_count),
    .done    (done)
  );

  assign green_dur = (data_in == '0) ? CNT_W'(1) : data_in;
  // Same-direction press while already serving it only extends the hold.
  assign em_same = (state_q == ST_EMERG) && (em_dir == dir_q);
  assign preempt = PREEMPT && em_pend_q &&
                   (gcnt_q >= CNT_W'(MIN_GREEN));

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rr_d      = rr_q;
    em_flag_d = em_flag_q;
    load      = 1'b0;
    load_val  = '0;
    em_clr    = 1'b0;
    ped_clr   = 1'b0;
    unique case (state_q)
      ST_ALLRED: begin
        if (done) begin
          load = 1'b1;
          if (em_pend_q) begin
            state_d   = ST_EMERG;
            dir_d     = em_dir_q;
            load_val  = CNT_W'(EMERG_T);
            em_clr    = 1'b1;
            em_flag_d = 1'b1;
          end else if (ped_pend_q) begin
            state_d  = ST_PED;
            load_val = CNT_W'(PED_T);
            ped_clr  = 1'b1;
          end else begin
            state_d  = ST_GREEN;
            dir_d    = pick_dir(veh_req, rr_q);
            load_val = green_dur;
          end
        end
      end
      ST_GREEN: begin
        if (done || preempt) begin
          state_d  = ST_YELLOW;
          load     = 1'b1;
          load_val = CNT_W'(YELLOW_T);
        end
      end
      ST_YELLOW: begin
        if (done) begin
          state_d   = ST_ALLRED;
          load      = 1'b1;
          load_val  = CNT_W'(ALLRED_T);
          em_flag_d = 1'b0;
          if (!em_flag_q) rr_d = dir_q + 2'd1;
        end
      end
      ST_PED: begin
        if (done) begin
          state_d  = ST_ALLRED;
          load     = 1'b1;
          load_val = CNT_W'(ALLRED_T);
        end
      end
      ST_EMERG: begin
        if (em_button && em_same) begin
          load     = 1'b1;
          load_val = CNT_W'(EMERG_T);
        end else if (done) begin
          state_d  = ST_YELLOW;
          load     = 1'b1;
          load_val = CNT_W'(YELLOW_T);
        end
      end
      default: begin
        state_d  = ST_ALLRED;
        load     = 1'b1;
        load_val = CNT_W'(ALLRED_T);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ALLRED;
      dir_q     <= DIR_N;
      rr_q      <= DIR_N;
      em_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rr_q      <= rr_d;
      em_flag_q <= em_flag_d;
    end
  end

  // A fresh request in the same cycle as the clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      em_pend_q  <= 1'b0;
      em_dir_q   <= DIR_N;
      ped_sync_q <= 2'b00;
      ped_pend_q <= 1'b0;
    end else begin
      ped_sync_q <= {ped_sync_q[0], ped_button};
      if (em_button && !em_same) begin
        em_pend_q <= 1'b1;
        em_dir_q  <= em_dir;
      end else if (em_clr) begin
        em_pend_q <= 1'b0;
      end
      if (ped_sync_q[1])
        ped_pend_q <= 1'b1;
      else if (ped_clr)
        ped_pend_q <= 1'b0;
    end
  end

  // Green cycles elapsed, counting the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gcnt_q <= '0;
    else if (state_d == ST_GREEN && state_q != ST_GREEN)
      gcnt_q <= CNT_W'(1);
    else if (state_q == ST_GREEN && gcnt_q != '1)
      gcnt_q <= gcnt_q + 1'b1;
  end

  always_comb begin
    lights   = '0;
    grant    = '0;
    ped_walk = 1'b0;
    unique case (state_q)
      ST_GREEN, ST_EMERG: begin
        lights[{dir_q, 1'b0} +: 2] = GREEN;
        grant = dir_onehot(dir_q);
      end
      ST_YELLOW: begin
        lights[{dir_q, 1'b0} +: 2] = YELLOW;
        grant = dir_onehot(dir_q);
      end
      ST_PED:    ped_walk = 1'b1;
      ST_ALLRED: ;
      default:   ;
    endcase
  end

  assign light_n   = lights[1:0];
  assign light_e   = lights[3:2];
  assign light_s   = lights[5:4];
  assign light_w   = lights[7:6];
  assign em_active = (state_q == ST_EMERG) ||
                     (state_q == ST_YELLOW && em_flag_q);

endmodule
